// File: rtl/frame_write_serializer.sv
// Buffers FMA_COUNT-wide batches of iteration counts and serialises them into one
// frame-buffer pixel write per cycle, with bank offset, clipping and drain-then-swap.
module frame_write_serializer #(
   parameter int unsigned FMA_COUNT  = 2,
   parameter int unsigned ITERS_BITS = 4,
   parameter int unsigned WIDTH      = 320,
   parameter int unsigned HEIGHT     = 160,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                   sys_clk_in,
   input  logic                                   rst_n_in,
   input  logic                                   batch_valid_in,
   output logic                                   batch_ready_out,
   input  logic [FMA_COUNT*ITERS_BITS-1:0]        batch_iters_in,
   input  logic [$clog2(WIDTH*HEIGHT)-1:0]        batch_addr_in,
   input  logic                                   swap_req_in,
   output logic                                   wr_valid_out,
   output logic [$clog2(2*WIDTH*HEIGHT)-1:0]      wr_addr_out,
   output logic [ITERS_BITS-1:0]                  wr_data_out,
   output logic                                   bank_out,
   output logic                                   swap_pending_out,
   output logic                                   swap_done_out,
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0]      pixels_written_out,
   output logic [15:0]                            dropped_out
);

   localparam int unsigned FRAME = WIDTH * HEIGHT;
   localparam int unsigned IW    = FMA_COUNT * ITERS_BITS;
   localparam int unsigned AW    = $clog2(FRAME);
   localparam int unsigned BAW   = $clog2(2 * FRAME);
   localparam int unsigned PCW   = $clog2(FRAME + 1);
   localparam int unsigned LW    = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
   localparam int unsigned FW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = FW + 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(FMA_COUNT - 1);

   typedef enum logic {SER_IDLE, SER_BUSY}    ser_state_t;
   typedef enum logic {SWAP_RUN, SWAP_DRAIN}  swap_state_t;

   ser_state_t  ser_state;
   swap_state_t swap_state;

   logic [IW+AW-1:0] fifo_mem [FIFO_DEPTH];
   logic [FW-1:0]    wr_ptr;
   logic [FW-1:0]    rd_ptr;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             lane_last;
   logic [IW+AW-1:0] fifo_head;

   logic [IW-1:0]    cur_iters;
   logic [31:0]      cur_pix;
   logic [LW-1:0]    lane_idx;

   assign fifo_full        = (fifo_count == CW'(FIFO_DEPTH));
   assign fifo_empty       = (fifo_count == '0);
   assign swap_pending_out = (swap_state == SWAP_DRAIN);
   assign batch_ready_out  = rst_n_in && !fifo_full && (swap_state == SWAP_RUN);
   assign push             = batch_valid_in && batch_ready_out;
   assign lane_last        = (ser_state == SER_BUSY) && (lane_idx == LAST_LANE);
   // Popping on the last lane keeps the pixel stream gap-free across batches.
   assign pop              = !fifo_empty && ((ser_state == SER_IDLE) || lane_last);
   assign fifo_head        = fifo_mem[rd_ptr];

   always_ff @(posedge sys_clk_in) begin
      if (push) fifo_mem[wr_ptr] <= {batch_iters_in, batch_addr_in};
   end

   always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ser_state          <= SER_IDLE;
         swap_state         <= SWAP_RUN;
         cur_iters          <= '0;
         cur_pix            <= '0;
         lane_idx           <= '0;
         wr_valid_out       <= 1'b0;
         wr_addr_out        <= '0;
         wr_data_out        <= '0;
         bank_out           <= 1'b0;
         swap_done_out      <= 1'b0;
         pixels_written_out <= '0;
         dropped_out        <= '0;
      end else begin
         wr_valid_out  <= 1'b0;
         swap_done_out <= 1'b0;

         if (ser_state == SER_BUSY) begin
            if (cur_pix < FRAME) begin
               wr_valid_out       <= 1'b1;
               wr_addr_out        <= BAW'(cur_pix + (bank_out ? FRAME : 32'd0));
               wr_data_out        <= cur_iters[IW-1 -: ITERS_BITS];
               pixels_written_out <= pixels_written_out + PCW'(1);
            end else if (dropped_out != '1) begin
               dropped_out <= dropped_out + 16'd1;
            end
            cur_iters <= cur_iters << ITERS_BITS;
            cur_pix   <= cur_pix + 32'd1;
            lane_idx  <= lane_idx + LW'(1);
         end

         if (pop) begin
            ser_state <= SER_BUSY;
            cur_iters <= fifo_head[IW+AW-1:AW];
            cur_pix   <= 32'(fifo_head[AW-1:0]);
            lane_idx  <= '0;
         end else if (lane_last) begin
            ser_state <= SER_IDLE;
         end

         // Toggle only once nothing of the old frame is queued or in flight.
         if (swap_state == SWAP_RUN) begin
            if (swap_req_in) swap_state <= SWAP_DRAIN;
         end else if (fifo_empty && (ser_state == SER_IDLE)) begin
            swap_state         <= SWAP_RUN;
            bank_out           <= ~bank_out;
            pixels_written_out <= '0;
            swap_done_out      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_write_serializer.sv
// Randomised and directed bench for frame_write_serializer, scored against a
// schedule-based reference model of write timing, clipping, FIFO occupancy and swaps.
module tb_frame_write_serializer;

   localparam int F     = 2;
   localparam int IB    = 4;
   localparam int W     = 320;
   localparam int H     = 160;
   localparam int DEPTH = 4;
   localparam int FRAME = W * H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        batch_valid = 1'b0;
   logic        batch_ready;
   logic [7:0]  batch_iters = '0;
   logic [15:0] batch_addr = '0;
   logic        swap_req = 1'b0;
   logic        wr_valid;
   logic [16:0] wr_addr;
   logic [3:0]  wr_data;
   logic        bank;
   logic        swap_pending;
   logic        swap_done;
   logic [15:0] pixels_written;
   logic [15:0] dropped;

   frame_write_serializer #(
      .FMA_COUNT(F), .ITERS_BITS(IB), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk_in(clk), .rst_n_in(rst_n),
      .batch_valid_in(batch_valid), .batch_ready_out(batch_ready),
      .batch_iters_in(batch_iters), .batch_addr_in(batch_addr),
      .swap_req_in(swap_req),
      .wr_valid_out(wr_valid), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
      .bank_out(bank), .swap_pending_out(swap_pending), .swap_done_out(swap_done),
      .pixels_written_out(pixels_written), .dropped_out(dropped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
   endtask

   // Reference model: each accepted batch is scheduled to issue its lanes at
   // max(accept+2, previous lane+1); a swap toggles one edge after the last old lane.
   int exp_addr [int];
   int exp_data [int];
   bit exp_clip [int];
   int pop_q [$];
   bit m_ready = 1'b1;
   bit m_pending = 1'b0;
   bit m_bank = 1'b0;
   bit m_done = 1'b0;
   int m_pw = 0;
   int m_drop = 0;
   int m_last = 0;
   int m_T = 0;
   bit acc;
   bit pend_before;
   int start;
   int p;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_ready = 1'b1; m_pending = 1'b0; m_bank = 1'b0; m_done = 1'b0;
         m_pw = 0; m_drop = 0; m_last = cyc;
         pop_q.delete(); exp_addr.delete(); exp_data.delete(); exp_clip.delete();
      end else begin
         pend_before = m_pending;
         acc = batch_valid && m_ready;
         m_done = 1'b0;
         if (exp_clip.exists(cyc)) begin
            if (exp_clip[cyc]) begin
               if (m_drop < 65535) m_drop++;
            end else m_pw++;
         end
         if (pend_before && cyc == m_T) begin
            m_bank = !m_bank; m_pw = 0; m_done = 1'b1; m_pending = 1'b0;
         end
         if (acc) begin
            start = (cyc + 2 > m_last + 1) ? cyc + 2 : m_last + 1;
            for (int i = 0; i < F; i++) begin
               p = int'(batch_addr) + i;
               exp_clip[start+i] = (p >= FRAME);
               exp_addr[start+i] = p + (m_bank ? FRAME : 0);
               exp_data[start+i] = (int'(batch_iters) >> (IB * (F - 1 - i))) & ((1 << IB) - 1);
            end
            m_last = start + F - 1;
            pop_q.push_back(start - 1);
         end
         if (!pend_before && swap_req) begin
            m_pending = 1'b1;
            m_T = (cyc + 1 > m_last + 1) ? cyc + 1 : m_last + 1;
         end
         while (pop_q.size() > 0 && pop_q[0] <= cyc) void'(pop_q.pop_front());
         m_ready = !m_pending && (pop_q.size() < DEPTH);
      end
   end

   bit ev;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_ready", int'(batch_ready), 0);
         check("rst_wr_valid", int'(wr_valid), 0);
         check("rst_wr_addr", int'(wr_addr), 0);
         check("rst_wr_data", int'(wr_data), 0);
         check("rst_bank", int'(bank), 0);
         check("rst_pending", int'(swap_pending), 0);
         check("rst_done", int'(swap_done), 0);
         check("rst_pw", int'(pixels_written), 0);
         check("rst_dropped", int'(dropped), 0);
      end else if (cyc > 0) begin
         ev = exp_clip.exists(cyc) && !exp_clip[cyc];
         check("wr_valid", int'(wr_valid), int'(ev));
         if (ev) begin
            check("wr_addr", int'(wr_addr), exp_addr[cyc]);
            check("wr_data", int'(wr_data), exp_data[cyc]);
         end
         check("ready", int'(batch_ready), int'(m_ready));
         check("bank", int'(bank), int'(m_bank));
         check("pending", int'(swap_pending), int'(m_pending));
         check("swap_done", int'(swap_done), int'(m_done));
         check("pixels_written", int'(pixels_written), m_pw);
         check("dropped", int'(dropped), m_drop);
         if (swap_done) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_batch(input logic [7:0] it, input logic [15:0] ad, input bit hold);
      bit ok;
      ok = 1'b0;
      batch_iters = it;
      batch_addr  = ad;
      batch_valid = 1'b1;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         ok = batch_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) check("accept_timeout", 0, 1);
      if (!hold) batch_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      send_batch(8'hA3, 16'd100, 1'b0);
      tick(6);
      check("single_pw", int'(pixels_written), 2);

      for (int j = 0; j < 6; j++) send_batch(8'(j * 17 + 1), 16'(2 * j), j < 5);
      tick(20);
      check("b2b_pw", int'(pixels_written), 14);

      send_batch(8'h5F, 16'd51199, 1'b0);
      tick(6);
      check("clip_dropped", int'(dropped), 1);
      check("clip_pw", int'(pixels_written), 15);

      for (int j = 0; j < 3; j++) send_batch(8'(8'h10 + j), 16'(200 + 2 * j), j < 2);
      swap_req = 1'b1;
      tick(1);
      swap_req = 1'b0;
      tick(12);
      check("swap_bank", int'(bank), 1);
      check("swap_pw", int'(pixels_written), 0);
      send_batch(8'h77, 16'd0, 1'b0);
      tick(5);

      d0 = done_cnt;
      swap_req = 1'b1;
      tick(2);
      swap_req = 1'b0;
      tick(4);
      check("dup_swap_pulses", done_cnt - d0, 1);
      check("dup_bank", int'(bank), 0);

      for (int c = 0; c < 400; c++) begin
         batch_valid = 1'($urandom_range(0, 1));
         batch_iters = 8'($urandom);
         if ($urandom_range(0, 3) == 0) batch_addr = 16'($urandom_range(FRAME - 3, FRAME + 3));
         else                           batch_addr = 16'($urandom_range(0, FRAME - 1));
         swap_req = ($urandom_range(0, 29) == 0);
         tick(1);
      end
      batch_valid = 1'b0;
      swap_req = 1'b0;
      tick(20);

      send_batch(8'hC6, 16'd300, 1'b0);
      tick(2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_wr_valid", int'(wr_valid), 0);
      check("async_rst_wr_addr", int'(wr_addr), 0);
      check("async_rst_wr_data", int'(wr_data), 0);
      check("async_rst_pw", int'(pixels_written), 0);
      check("async_rst_ready", int'(batch_ready), 0);
      tick(2);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", int'(batch_ready), 1);
      check("post_rst_bank", int'(bank), 0);
      tick(3);
      send_batch(8'h3C, 16'd5, 1'b0);
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frame_write_serializer.md
# frame_write_serializer

Single-clock, parametrised successor to the dual frame buffer write path. Accepts batches of FMA_COUNT Mandelbrot iteration counts from the GPU over a valid/ready handshake and buffers them in a batch FIFO. Serialises the batches into one pixel write per cycle for the frame-buffer BRAM write port, with bank-offset addressing, out-of-frame clipping and a drain-then-swap bank handshake. Sits between the FMA array and the BRAM write port; the HDMI read side is out of scope.

## Interface

Parameters:
- FMA_COUNT, 2, iteration counts per batch (≥1)
- ITERS_BITS, 4, bits per iteration count
- WIDTH, 320, frame width in pixels
- HEIGHT, 160, frame height in pixels
- FIFO_DEPTH, 4, batch FIFO entries (power of two, ≥2)

Ports:
- sys_clk_in  in  1  system clock; all logic on its rising edge
- rst_n_in  in  1  reset; asynchronous, active-low
- batch_valid_in  in  1  batch present
- batch_ready_out  out  1  block can accept a batch
- batch_iters_in  in  FMA_COUNT*ITERS_BITS  lane 0 in the most-significant slice
- batch_addr_in  in  $clog2(WIDTH*HEIGHT)  pixel address of lane 0
- swap_req_in  in  1  one-cycle request to swap write bank
- wr_valid_out  out  1  pixel write strobe
- wr_addr_out  out  $clog2(2*WIDTH*HEIGHT)  BRAM address, bank offset included
- wr_data_out  out  ITERS_BITS  iteration count to write
- bank_out  out  1  current write bank (0 = A, 1 = B)
- swap_pending_out  out  1  swap requested, not yet executed
- swap_done_out  out  1  one-cycle pulse after bank toggles
- pixels_written_out  out  $clog2(WIDTH*HEIGHT+1)  in-frame writes since last swap
- dropped_out  out  16  clipped pixels since reset, saturating

## Operation

- Accept on batch_valid_in && batch_ready_out. Push {iters, addr} into FIFO.
- batch_ready_out = !fifo_full && !swap_pending, from registered state only (no push-through when full); 0 while rst_n_in low.
- Serializer states: IDLE, BUSY. IDLE→BUSY when FIFO non-empty (pop, lane index := 0). In BUSY, one lane per cycle. Lane i goes to pixel address batch_addr + i, with data = slice [ITERS_BITS*(FMA_COUNT-1-i) +: ITERS_BITS].
- On the last lane, pop the next entry in the same cycle if the FIFO is non-empty (no bubble); otherwise BUSY→IDLE.
- Pixel address p ≥ WIDTH*HEIGHT: the write is clipped. wr_valid_out stays 0 for that cycle and dropped_out increments, saturating at 16'hFFFF. The lane still consumes its cycle.
- wr_addr_out = p + (bank_out ? WIDTH*HEIGHT : 0). The bank is sampled when the lane issues.
- pixels_written_out increments per in-frame write; it clears to 0 at swap.
- Swap FSM states: RUN, DRAIN.
  - RUN→DRAIN on swap_req_in.
  - DRAIN→RUN at the first edge where the FIFO is empty and the serializer is IDLE (no lane issuing). At that edge bank_out toggles and pixels_written_out clears.
  - swap_req_in in DRAIN is ignored (merged).
  - A batch accepted in the same cycle swap_req_in is asserted belongs to the old frame and is drained before the swap.
- Reset (asynchronous, any time, mid-batch included): FIFO empty, serializer IDLE, swap FSM RUN. bank_out=0, swap_pending_out=0, swap_done_out=0, wr_valid_out=0, wr_addr_out=0, wr_data_out=0, pixels_written_out=0, dropped_out=0. Partially serialised batches are discarded.

## Timing

- All outputs except batch_ready_out are registered.
- Latency: batch accepted at edge k into an empty, idle block → lane 0 write visible after edge k+2. Lane i is visible after edge k+2+i.
- Sustained throughput: 1 pixel/cycle, i.e. 1 batch per FMA_COUNT cycles, with no gaps between batches while the FIFO is non-empty.
- Swap: swap_req_in sampled at edge e with the block idle → swap_pending_out high after e. The bank toggles at e+1, and swap_done_out is high for the cycle after e+1. The last old-frame write is issued before the toggle edge and carries the old bank offset.
- batch_ready_out is low from the edge after swap_req_in through the toggle edge, and high again in the swap_done_out cycle if the FIFO is not full.

## Test plan

Defaults apply, plus FIFO_DEPTH=4.
- Single batch: iters=8'hA3, addr=100, bank 0 → writes (100,4'hA) then (101,4'h3) after edges k+2 and k+3; pixels_written_out=2.
- Back-to-back: 6 batches with valid held high and addresses 0,2,…,10 → 12 consecutive wr_valid_out cycles with no gap. Ready drops while 4 entries are buffered.
- Clipping: addr=51199, iters=8'h5F → a single write (51199,4'h5), then one cycle with wr_valid_out=0; dropped_out=1.
- Swap with backlog: 3 batches queued, then swap_req_in → ready low. All 6 writes carry bank-0 addresses, then bank_out=1 and swap_done_out pulses once. The next batch at addr=0 writes address 51200.
- Duplicate swap: swap_req_in on two consecutive cycles → exactly one toggle and one swap_done_out pulse.
- Reset mid-batch: rst_n_in low during lane 1 → all outputs return to reset values immediately; after release, batch_ready_out=1 and bank_out=0.
